// File: rtl/present_round_scheduler_if.sv
// Handshake and strobe bundle between the PRESENT round scheduler and its
// neighbours (bus wrapper upstream, state/key datapath downstream).
interface present_round_scheduler_if #(
  parameter int CNT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             abort;
  logic             load_state;
  logic             round_en;
  logic             final_en;
  logic [CNT_W-1:0] round_count;
  logic             busy;
  logic             out_valid;
  logic             out_ready;

  // Side that offers plaintext blocks and consumes ciphertext.
  modport master (
    output in_valid, abort, out_ready,
    input  in_ready, load_state, round_en, final_en, round_count, busy, out_valid
  );

  // The scheduler itself.
  modport slave (
    input  in_valid, abort, out_ready,
    output in_ready, load_state, round_en, final_en, round_count, busy, out_valid
  );
endinterface

// File: rtl/present_round_scheduler.sv
// Sequencing FSM for the round-based PRESENT datapath: accepts a block,
// issues NUM_ROUNDS round strobes with the key-schedule round index, one
// final-whitening strobe, then holds the ciphertext valid until consumed.
module present_round_scheduler #(
  parameter int NUM_ROUNDS = 31,
  parameter int CNT_W      = 5
) (
  input logic                    clk,
  input logic                    n_reset,
  present_round_scheduler_if.slave bus
);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS >= (1 << CNT_W)) begin : g_bad_rounds
    $error("present_round_scheduler: NUM_ROUNDS must be in 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS);
  localparam logic [CNT_W-1:0] FIRST_ROUND = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FINAL = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             in_ready;
  logic             load_state;
  logic             round_en;
  logic             final_en;
  logic             busy;
  logic             out_valid;

  // State register and round counter; reset returns to IDLE with a cleared index.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; abort outranks both the counter advance and out_ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (load_state) begin
          state_d = S_RUN;
          cnt_d   = FIRST_ROUND;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_ROUND) begin
          state_d = S_FINAL;
        end else begin
          cnt_d = cnt_q + FIRST_ROUND;
        end
      end
      S_FINAL: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.abort || bus.out_ready) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode: strobes come straight from the state register; only the
  // input handshake looks at reset and in_valid.
  always_comb begin
    in_ready   = n_reset && (state_q == S_IDLE);
    load_state = in_ready && bus.in_valid;
    round_en   = (state_q == S_RUN);
    final_en   = (state_q == S_FINAL);
    busy       = (state_q == S_RUN) || (state_q == S_FINAL);
    out_valid  = (state_q == S_OUT);
  end

  assign bus.in_ready    = in_ready;
  assign bus.load_state  = load_state;
  assign bus.round_en    = round_en;
  assign bus.final_en    = final_en;
  assign bus.busy        = busy;
  assign bus.out_valid   = out_valid;
  assign bus.round_count = cnt_q;

endmodule

// File: tb/tb_present_round_scheduler.sv
// Directed bench for present_round_scheduler (NUM_ROUNDS=31, CNT_W=5).
module tb_present_round_scheduler;

  logic clk;
  logic n_reset;

  int n_checks;
  int n_errors;
  int hs_cycle [0:3];
  int hs_count;

  present_round_scheduler_if #(.CNT_W(5)) bus ();

  present_round_scheduler #(
    .NUM_ROUNDS(31),
    .CNT_W     (5)
  ) dut (
    .clk    (clk),
    .n_reset(n_reset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector: {in_ready, load_state, round_en, final_en, busy, out_valid, round_count}
  function automatic logic [10:0] ev(input logic ir, input logic ld, input logic re,
                                     input logic fe, input logic bz, input logic ov,
                                     input int cnt);
    logic [4:0] c;
    c = cnt[4:0];
    return {ir, ld, re, fe, bz, ov, c};
  endfunction

  task automatic chk(input string tag, input logic [10:0] expv);
    logic [10:0] obs;
    obs = {bus.in_ready, bus.load_state, bus.round_en, bus.final_en,
           bus.busy, bus.out_valid, bus.round_count};
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // One clock: move past the edge, drive inputs, let combinational outputs settle.
  task automatic cycle(input logic iv, input logic ab, input logic ordy);
    step();
    bus.in_valid  = iv;
    bus.abort     = ab;
    bus.out_ready = ordy;
    settle();
  endtask

  task automatic rounds(input int first, input int last, input string tag);
    for (int r = first; r <= last; r++) begin
      cycle(1'b0, 1'b0, 1'b1);
      chk(tag, ev(0, 0, 1, 0, 1, 0, r));
    end
  endtask

  // From just after the load cycle: all rounds, final, one OUT cycle, IDLE.
  task automatic finish_block(input string tag);
    rounds(1, 31, {tag, "_round"});
    cycle(1'b0, 1'b0, 1'b1);
    chk({tag, "_final"}, ev(0, 0, 0, 1, 1, 0, 31));
    cycle(1'b0, 1'b0, 1'b1);
    chk({tag, "_out"}, ev(0, 0, 0, 0, 0, 1, 31));
    cycle(1'b0, 1'b0, 1'b1);
    chk({tag, "_idle"}, ev(1, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    hs_count      = 0;
    n_reset       = 1'b0;
    bus.in_valid  = 1'b1;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;

    // 1: reset held three cycles with in_valid high
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      chk("reset", ev(0, 0, 0, 0, 0, 0, 0));
    end

    // 2: single block
    step();
    n_reset       = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    settle();
    chk("single_load", ev(1, 1, 0, 0, 0, 0, 0));
    finish_block("single");

    // 3: output stall
    cycle(1'b1, 1'b0, 1'b0);
    chk("stall_load", ev(1, 1, 0, 0, 0, 0, 0));
    for (int r = 1; r <= 31; r++) begin
      cycle(1'b0, 1'b0, 1'b0);
      chk("stall_round", ev(0, 0, 1, 0, 1, 0, r));
    end
    cycle(1'b0, 1'b0, 1'b0);
    chk("stall_final", ev(0, 0, 0, 1, 1, 0, 31));
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      chk("stall_hold", ev(0, 0, 0, 0, 0, 1, 31));
    end
    cycle(1'b0, 1'b0, 1'b1);
    chk("stall_release", ev(0, 0, 0, 0, 0, 1, 31));
    cycle(1'b0, 1'b0, 1'b1);
    chk("stall_idle", ev(1, 0, 0, 0, 0, 0, 0));

    // 4: abort at round_count 12, then a normal block
    cycle(1'b1, 1'b0, 1'b1);
    chk("abort_load", ev(1, 1, 0, 0, 0, 0, 0));
    rounds(1, 11, "abort_round");
    cycle(1'b0, 1'b1, 1'b1);
    chk("abort_r12", ev(0, 0, 1, 0, 1, 0, 12));
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      chk("abort_idle", ev(1, 0, 0, 0, 0, 0, 0));
    end
    cycle(1'b1, 1'b0, 1'b1);
    chk("after_abort_load", ev(1, 1, 0, 0, 0, 0, 0));
    finish_block("after_abort");

    // 5: abort in IDLE ignored; in_valid pulses during RUN ignored
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 1'b1);
      chk("idle_abort", ev(1, 0, 0, 0, 0, 0, 0));
    end
    cycle(1'b1, 1'b1, 1'b1);
    chk("idle_abort_load", ev(1, 1, 0, 0, 0, 0, 0));
    for (int r = 1; r <= 31; r++) begin
      cycle((r == 5 || r == 20), 1'b0, 1'b1);
      chk("ignore_round", ev(0, 0, 1, 0, 1, 0, r));
    end
    cycle(1'b1, 1'b0, 1'b1);
    chk("ignore_final", ev(0, 0, 0, 1, 1, 0, 31));
    cycle(1'b0, 1'b0, 1'b1);
    chk("ignore_out", ev(0, 0, 0, 0, 0, 1, 31));
    cycle(1'b0, 1'b0, 1'b1);
    chk("ignore_idle", ev(1, 0, 0, 0, 0, 0, 0));

    // 6: reset during FINAL
    cycle(1'b1, 1'b0, 1'b1);
    chk("rstfin_load", ev(1, 1, 0, 0, 0, 0, 0));
    rounds(1, 31, "rstfin_round");
    step();
    n_reset      = 1'b0;
    bus.in_valid = 1'b0;
    settle();
    chk("rstfin_final", ev(0, 0, 0, 1, 1, 0, 31));
    step();
    n_reset = 1'b1;
    settle();
    chk("rstfin_idle", ev(1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      chk("rstfin_quiet", ev(1, 0, 0, 0, 0, 0, 0));
    end

    // abort in FINAL, and abort in OUT while out_ready is low
    cycle(1'b1, 1'b0, 1'b0);
    chk("abtfin_load", ev(1, 1, 0, 0, 0, 0, 0));
    rounds(1, 31, "abtfin_round");
    cycle(1'b0, 1'b1, 1'b0);
    chk("abtfin_final", ev(0, 0, 0, 1, 1, 0, 31));
    cycle(1'b0, 1'b0, 1'b0);
    chk("abtfin_idle", ev(1, 0, 0, 0, 0, 0, 0));
    cycle(1'b1, 1'b0, 1'b0);
    chk("abtout_load", ev(1, 1, 0, 0, 0, 0, 0));
    rounds(1, 31, "abtout_round");
    cycle(1'b0, 1'b0, 1'b0);
    chk("abtout_final", ev(0, 0, 0, 1, 1, 0, 31));
    cycle(1'b0, 1'b0, 1'b0);
    chk("abtout_out", ev(0, 0, 0, 0, 0, 1, 31));
    cycle(1'b0, 1'b1, 1'b0);
    chk("abtout_out2", ev(0, 0, 0, 0, 0, 1, 31));
    cycle(1'b0, 1'b0, 1'b0);
    chk("abtout_idle", ev(1, 0, 0, 0, 0, 0, 0));

    // 7: back-to-back blocks, handshakes 34 cycles apart
    for (int c = 0; c < 75; c++) begin
      cycle(1'b1, 1'b0, 1'b1);
      if (bus.load_state === 1'b1 && hs_count < 4) begin
        hs_cycle[hs_count] = c;
        hs_count++;
      end
    end
    chk_int("b2b_count", hs_count, 3);
    chk_int("b2b_first", hs_cycle[0], 0);
    chk_int("b2b_gap1", hs_cycle[1] - hs_cycle[0], 34);
    chk_int("b2b_gap2", hs_cycle[2] - hs_cycle[1], 34);

    cycle(1'b0, 1'b0, 1'b1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
